s2p: RTL and testbench

Serial-to-parallel receiver for the ADC readout link: the far-end counterpart of the block that shifts 12-bit ADC words out, LSB first, on `s_data` while `data_valid` is low. It sits in the FPGA/test-side capture path on the 50 MHz system clock. It reassembles each serial word and presents it with a one-cycle ready strobe. It also reports truncated words and the number of complete words per burst.

---
 rtl/s2p.sv | 120 ++++++++++++
 tb/tb_s2p.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/s2p.sv
// Serial-to-parallel receiver for the ADC readout link: rebuilds LSB-first words
// framed by an active-low data_valid and reports per-burst word counts and truncation.
module s2p #(
    parameter int unsigned BITS_ADC = 12,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk_50M,
    input  logic                rst_n,
    input  logic                s_data,
    input  logic                data_valid,
    output logic [BITS_ADC-1:0] p_data_out,
    output logic                p_data_rdy,
    output logic                frame_err,
    output logic                burst_done,
    output logic [CNT_W-1:0]    burst_words
);

    localparam int unsigned BC_W = (BITS_ADC > 1) ? $clog2(BITS_ADC) : 1;
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(BITS_ADC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic                sd_r, dv_r;
    logic [BITS_ADC-1:0] shreg, shreg_nxt, shifted;
    logic [BC_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [CNT_W-1:0]    wcnt, wcnt_nxt;
    logic [BITS_ADC-1:0] data_nxt;
    logic                rdy_nxt, ferr_nxt, done_nxt;
    logic [CNT_W-1:0]    bw_nxt;

    // Input register stage; the raw pins feed nothing else.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sd_r <= 1'b0;
            dv_r <= 1'b1;
        end else begin
            sd_r <= s_data;
            dv_r <= data_valid;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            wcnt        <= '0;
            p_data_out  <= '0;
            p_data_rdy  <= 1'b0;
            frame_err   <= 1'b0;
            burst_done  <= 1'b0;
            burst_words <= '0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            wcnt        <= wcnt_nxt;
            p_data_out  <= data_nxt;
            p_data_rdy  <= rdy_nxt;
            frame_err   <= ferr_nxt;
            burst_done  <= done_nxt;
            burst_words <= bw_nxt;
        end
    end

    assign shifted = {sd_r, shreg[BITS_ADC-1:1]};

    // Next-state and output decode; a raised data_valid in RECV closes the burst.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        wcnt_nxt    = wcnt;
        data_nxt    = p_data_out;
        rdy_nxt     = 1'b0;
        ferr_nxt    = 1'b0;
        done_nxt    = 1'b0;
        bw_nxt      = burst_words;

        case (state)
            IDLE: begin
                if (!dv_r) begin
                    shreg_nxt   = shifted;
                    bit_cnt_nxt = BC_W'(1);
                    wcnt_nxt    = '0;
                    state_nxt   = RECV;
                end
            end
            RECV: begin
                if (!dv_r) begin
                    shreg_nxt = shifted;
                    if (bit_cnt == LAST_BIT) begin
                        data_nxt    = shifted;
                        rdy_nxt     = 1'b1;
                        bit_cnt_nxt = '0;
                        if (wcnt != CNT_MAX) begin
                            wcnt_nxt = wcnt + CNT_W'(1);
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BC_W'(1);
                    end
                end else begin
                    done_nxt    = 1'b1;
                    bw_nxt      = wcnt;
                    ferr_nxt    = (bit_cnt != '0);
                    bit_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_s2p.sv
// Randomized bench for s2p: a bit-level burst model predicts every word, its
// arrival cycle and each burst summary; a negedge monitor scores the DUT.
module tb_s2p;

    localparam int unsigned BITS = 12;
    localparam int unsigned CW   = 8;
    localparam int          SAT  = 255;

    logic            clk_50M    = 1'b0;
    logic            rst_n      = 1'b0;
    logic            s_data     = 1'b0;
    logic            data_valid = 1'b1;
    logic [BITS-1:0] p_data_out;
    logic            p_data_rdy;
    logic            frame_err;
    logic            burst_done;
    logic [CW-1:0]   burst_words;

    s2p #(.BITS_ADC(BITS), .CNT_W(CW)) dut (
        .clk_50M     (clk_50M),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .data_valid  (data_valid),
        .p_data_out  (p_data_out),
        .p_data_rdy  (p_data_rdy),
        .frame_err   (frame_err),
        .burst_done  (burst_done),
        .burst_words (burst_words)
    );

    always #10 clk_50M = ~clk_50M;

    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    typedef struct {
        int word;
        int at;
    } word_exp_t;

    typedef struct {
        int at;
        int cnt;
        int ferr;
        int last;
    } burst_exp_t;

    word_exp_t  wq[$];
    burst_exp_t bq[$];

    int n_checks    = 0;
    int n_fail      = 0;
    int nb          = 0;
    int nw          = 0;
    int last_word   = 0;
    int sent_words  = 0;
    int seen_words  = 0;
    logic [BITS-1:0] acc = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One serial bit; every BITS-th bit of a burst completes a word.
    task automatic drive_bit(input logic b);
        @(negedge clk_50M);
        s_data     = b;
        data_valid = 1'b0;
        acc[nb % BITS] = b;
        nb++;
        if (nb % BITS == 0) begin
            wq.push_back('{word: int'(acc), at: cyc + 2});
            last_word = int'(acc);
            nw++;
            sent_words++;
        end
    endtask

    task automatic drive_idle();
        @(negedge clk_50M);
        data_valid = 1'b1;
        s_data     = 1'($urandom);
        if (nb > 0) begin
            bq.push_back('{at: cyc + 2, cnt: (nw > SAT) ? SAT : nw,
                           ferr: int'((nb % BITS) != 0), last: last_word});
            nb = 0;
            nw = 0;
        end
    endtask

    task automatic send_word(input logic [BITS-1:0] w);
        for (int i = 0; i < int'(BITS); i++) drive_bit(w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_idle();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data"}, 32'(p_data_out), 0);
        check({tag, "_rdy"},  32'(p_data_rdy), 0);
        check({tag, "_ferr"}, 32'(frame_err), 0);
        check({tag, "_done"}, 32'(burst_done), 0);
        check({tag, "_bw"},   32'(burst_words), 0);
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clk_50M) begin
        if (rst_n) begin
            if (p_data_rdy) begin
                seen_words++;
                if (wq.size() == 0) begin
                    check("rdy_unexpected", 32'(p_data_rdy), 0);
                end else begin
                    word_exp_t e;
                    e = wq.pop_front();
                    check("word_data", 32'(p_data_out), e.word);
                    check("word_time", cyc, e.at);
                end
            end
            if (burst_done) begin
                if (bq.size() == 0) begin
                    check("done_unexpected", 32'(burst_done), 0);
                end else begin
                    burst_exp_t b;
                    b = bq.pop_front();
                    check("burst_time",  cyc, b.at);
                    check("burst_words", 32'(burst_words), b.cnt);
                    check("frame_err",   32'(frame_err), b.ferr);
                    check("data_hold",   32'(p_data_out), b.last);
                end
            end else if (frame_err) begin
                check("ferr_without_done", 32'(frame_err), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nbits;
        repeat (3) @(negedge clk_50M);
        check_reset_vals("por");
        @(negedge clk_50M);
        rst_n = 1'b1;
        idle(2);

        // Single word
        send_word(12'hA5C);
        idle(3);

        // Back-to-back words in one burst
        send_word(12'h001);
        send_word(12'hFFF);
        send_word(12'h800);
        idle(3);

        // Truncated burst
        for (int i = 0; i < 5; i++) drive_bit(1'($urandom));
        idle(3);

        // Asynchronous reset mid-word
        for (int i = 0; i < 7; i++) drive_bit(1'($urandom));
        #3;
        rst_n      = 1'b0;
        data_valid = 1'b1;
        wq.delete();
        bq.delete();
        nb        = 0;
        nw        = 0;
        last_word = 0;
        #1;
        check_reset_vals("async_rst");
        repeat (2) @(negedge clk_50M);
        check_reset_vals("held_rst");
        rst_n = 1'b1;
        idle(2);
        send_word(12'h3C3);
        idle(3);

        // Word counter saturation
        repeat (300) send_word(BITS'($urandom));
        idle(3);

        // Two bursts separated by a single high cycle
        send_word(BITS'($urandom));
        send_word(BITS'($urandom));
        idle(1);
        send_word(BITS'($urandom));
        for (int i = 0; i < 3; i++) drive_bit(1'($urandom));
        idle(3);

        // Random burst lengths and gaps
        repeat (10) begin
            nbits = int'($urandom_range(1, 50));
            for (int i = 0; i < nbits; i++) drive_bit(1'($urandom));
            idle(int'($urandom_range(1, 3)));
        end
        idle(4);

        check("words_left",  wq.size(), 0);
        check("bursts_left", bq.size(), 0);
        check("rdy_count",   seen_words, sent_words);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
